bcd_display_scan: RTL and testbench

Time-multiplexed driver for a 4-digit common-anode 7-segment display, consuming the four BCD millisecond digits produced by the reaction-time counter. It captures the digit values on a load strobe, scans one digit at a time at a parameterised refresh rate, and decodes BCD to segment patterns. It also applies an optional blink and per-digit decimal points. It sits between the timing datapath and the board display pins.

---
 rtl/bcd_display_scan_if.sv | 24 ++
 rtl/bcd_display_scan.sv | 121 ++++++++++++
 tb/tb_bcd_display_scan.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/bcd_display_scan_if.sv
// Digit/strobe inputs and display pin outputs of bcd_display_scan.
// The master drives digits and strobes; the slave (the scanner) drives the pins.
interface bcd_display_scan_if;
  logic       load;
  logic [3:0] d0;
  logic [3:0] d1;
  logic [3:0] d2;
  logic [3:0] d3;
  logic [3:0] dp_mask;
  logic       blink;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output load, d0, d1, d2, d3, dp_mask, blink,
    input  an, seg, dp
  );

  modport slave (
    input  load, d0, d1, d2, d3, dp_mask, blink,
    output an, seg, dp
  );
endinterface

// File: rtl/bcd_display_scan.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with blink and decimal points.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module bcd_display_scan #(
  parameter int unsigned PRESCALE    = 100000,
  parameter int unsigned BLINK_SLOTS = 256
) (
  input logic              ck,
  input logic              reset,
  bcd_display_scan_if.slave bus
);

  localparam logic [19:0] PRE_LAST   = 20'(PRESCALE - 1);
  localparam logic [15:0] SLOT_LAST  = 16'(BLINK_SLOTS - 1);

  logic [3:0]  hold_q [4];
  logic [3:0]  hold_d [4];
  logic [3:0]  hold_dp_q, hold_dp_d;
  logic [19:0] pre_q, pre_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] slot_q, slot_d;
  logic        phase_q, phase_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;

  logic        tick;
  logic [3:0]  digit_blank;
  logic        sel_blank;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank only if it and every more significant digit are zero with no dp.
  always_comb begin
    digit_blank    = '0;
    digit_blank[3] = (hold_q[3] == 4'd0) && !hold_dp_q[3];
    digit_blank[2] = (hold_q[2] == 4'd0) && !hold_dp_q[2] && digit_blank[3];
    digit_blank[1] = (hold_q[1] == 4'd0) && !hold_dp_q[1] && digit_blank[2];
  end
`else
  assign digit_blank = '0;
`endif

  assign sel_blank = digit_blank[idx_q];

  always_comb begin
    tick      = (pre_q == PRE_LAST);
    pre_d     = tick ? '0 : pre_q + 20'd1;
    idx_d     = tick ? idx_q + 2'd1 : idx_q;
    slot_d    = slot_q;
    phase_d   = phase_q;
    if (tick) begin
      if (slot_q == SLOT_LAST) begin
        slot_d  = '0;
        phase_d = ~phase_q;
      end else begin
        slot_d  = slot_q + 16'd1;
      end
    end

    hold_d    = hold_q;
    hold_dp_d = hold_dp_q;
    if (bus.load) begin
      hold_d[0] = bus.d0;
      hold_d[1] = bus.d1;
      hold_d[2] = bus.d2;
      hold_d[3] = bus.d3;
      hold_dp_d = bus.dp_mask;
    end

    // Outputs follow the current (pre-update) idx/hold, so a same-cycle tick and load never mix.
    an_d  = (bus.blink && phase_q) ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_d = sel_blank ? 7'b1111111 : bcd_to_seg(hold_q[idx_q]);
    dp_d  = sel_blank ? 1'b1 : ~hold_dp_q[idx_q];
  end

  always_ff @(posedge ck) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) hold_q[i] <= '0;
      hold_dp_q <= '0;
      pre_q     <= '0;
      idx_q     <= '0;
      slot_q    <= '0;
      phase_q   <= 1'b0;
      an_q      <= '1;
      seg_q     <= '1;
      dp_q      <= 1'b1;
    end else begin
      for (int unsigned i = 0; i < 4; i++) hold_q[i] <= hold_d[i];
      hold_dp_q <= hold_dp_d;
      pre_q     <= pre_d;
      idx_q     <= idx_d;
      slot_q    <= slot_d;
      phase_q   <= phase_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed, table-driven bench for bcd_display_scan (PRESCALE=4, BLINK_SLOTS=4).
// Expected glyphs follow the LEADING_ZERO_BLANK_EN setting of the build.
module tb_bcd_display_scan;

  logic ck = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  bcd_display_scan_if bus ();

  bcd_display_scan #(
    .PRESCALE   (4),
    .BLINK_SLOTS(4)
  ) dut (
    .ck   (ck),
    .reset(reset),
    .bus  (bus)
  );

  always #5 ck = ~ck;

  typedef struct packed {
    logic [15:0] digs;  // {d3,d2,d1,d0}
    logic [3:0]  dpm;
    logic [27:0] segs;  // {seg3,seg2,seg1,seg0}
    logic [3:0]  dps;   // expected dp output per digit
  } vec_t;

  localparam int NV = 6;
  vec_t vec [NV];

  task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_an"},  {3'b000, bus.an}, {3'b000, 4'b1111});
    chk({tag, "_seg"}, bus.seg, 7'b1111111);
    chk({tag, "_dp"},  {6'b0, bus.dp}, 7'd1);
  endtask

  // Caller sits at a negedge; leaves 3 reset edges behind it.
  task automatic hold_reset();
    reset    = 1'b1;
    bus.load = 1'b0;
    repeat (3) @(negedge ck);
  endtask

  task automatic set_digits(input logic [15:0] digs, input logic [3:0] dpm);
    bus.d0      = digs[3:0];
    bus.d1      = digs[7:4];
    bus.d2      = digs[11:8];
    bus.d3      = digs[15:12];
    bus.dp_mask = dpm;
  endtask

  initial begin
    logic [3:0] sel;
    reset       = 1'b1;
    bus.load    = 1'b0;
    bus.blink   = 1'b0;
    set_digits(16'h0000, 4'b0000);

    vec[0] = '{16'h9810, 4'b0100, {7'b0010000, 7'b0000000, 7'b1111001, 7'b1000000}, 4'b1011};
    vec[1] = '{16'h321C, 4'b0000, {7'b0110000, 7'b0100100, 7'b1111001, 7'b0111111}, 4'b1111};
    vec[4] = '{16'h0042, 4'b1000, {7'b1000000, 7'b1000000, 7'b0011001, 7'b0100100}, 4'b0111};
`ifdef LEADING_ZERO_BLANK_EN
    vec[2] = '{16'h0007, 4'b0000, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000}, 4'b1111};
    vec[3] = '{16'h0000, 4'b0000, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b1111};
    vec[5] = '{16'h0506, 4'b0001, {7'b1111111, 7'b0010010, 7'b1000000, 7'b0000010}, 4'b1110};
`else
    vec[2] = '{16'h0007, 4'b0000, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1111000}, 4'b1111};
    vec[3] = '{16'h0000, 4'b0000, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b1111};
    vec[5] = '{16'h0506, 4'b0001, {7'b1000000, 7'b0010010, 7'b1000000, 7'b0000010}, 4'b1110};
`endif

    // Reset values and anode stepping
    @(negedge ck);
    hold_reset();
    chk_reset_outputs("rst");
    reset = 1'b0;
    for (int e = 1; e <= 17; e++) begin
      @(negedge ck);
      case (e)
        1, 4: chk("scan_an0", {3'b0, bus.an}, {3'b0, 4'b1110});
        5:    chk("scan_an1", {3'b0, bus.an}, {3'b0, 4'b1101});
        9:    chk("scan_an2", {3'b0, bus.an}, {3'b0, 4'b1011});
        13:   chk("scan_an3", {3'b0, bus.an}, {3'b0, 4'b0111});
        17:   chk("scan_wrap", {3'b0, bus.an}, {3'b0, 4'b1110});
        default: ;
      endcase
    end

    // Decode vectors: load on first post-reset edge, sample each digit mid-slot
    for (int v = 0; v < NV; v++) begin
      hold_reset();
      set_digits(vec[v].digs, vec[v].dpm);
      bus.load = 1'b1;
      reset    = 1'b0;
      @(negedge ck);
      bus.load = 1'b0;
      for (int e = 2; e <= 15; e++) begin
        @(negedge ck);
        if (e % 4 == 3) begin
          sel = 4'b0001 << (e / 4);
          chk($sformatf("v%0d_an%0d", v, e / 4), {3'b0, bus.an}, {3'b0, ~sel});
          chk($sformatf("v%0d_seg%0d", v, e / 4), bus.seg, vec[v].segs[(e / 4) * 7 +: 7]);
          chk($sformatf("v%0d_dp%0d", v, e / 4), {6'b0, bus.dp}, {6'b0, vec[v].dps[e / 4]});
        end
      end
    end

    // Load latency on the selected digit, then load coinciding with a slot tick
    hold_reset();
    set_digits(16'h0001, 4'b0000);
    bus.load = 1'b1;
    reset    = 1'b0;
    @(negedge ck);                       // e1
    bus.load = 1'b0;
    @(negedge ck);                       // e2
    chk("lat_old", bus.seg, 7'b1111001);
    set_digits(16'h0003, 4'b0000);
    bus.load = 1'b1;
    @(negedge ck);                       // e3: hold captures 3
    chk("lat_same_edge", bus.seg, 7'b1111001);
    set_digits(16'h0053, 4'b0000);
    @(negedge ck);                       // e4: tick and load together
    bus.load = 1'b0;
    chk("lat_next_edge", bus.seg, 7'b0110000);
    chk("tick_an_old", {3'b0, bus.an}, {3'b0, 4'b1110});
    @(negedge ck);                       // e5
    chk("tick_an_new", {3'b0, bus.an}, {3'b0, 4'b1101});
    chk("tick_seg_new", bus.seg, 7'b0010010);

    // Blink: 16 lit cycles, 16 dark cycles; deassert mid-dark resumes at once
    hold_reset();
    bus.blink = 1'b1;
    reset     = 1'b0;
    for (int e = 1; e <= 33; e++) begin
      @(negedge ck);
      case (e)
        16: chk("blink_lit_end", {3'b0, bus.an}, {3'b0, 4'b0111});
        17: chk("blink_dark", {3'b0, bus.an}, {3'b0, 4'b1111});
        20: begin
          chk("blink_dark2", {3'b0, bus.an}, {3'b0, 4'b1111});
          bus.blink = 1'b0;
        end
        21: begin
          chk("blink_off", {3'b0, bus.an}, {3'b0, 4'b1101});
          bus.blink = 1'b1;
        end
        22: chk("blink_back_on", {3'b0, bus.an}, {3'b0, 4'b1111});
        32: chk("blink_dark_end", {3'b0, bus.an}, {3'b0, 4'b1111});
        33: chk("blink_relit", {3'b0, bus.an}, {3'b0, 4'b1110});
        default: ;
      endcase
    end
    bus.blink = 1'b0;

    // Reset with load while digit2 is selected
    hold_reset();
    set_digits(16'h9810, 4'b0100);
    bus.load = 1'b1;
    reset    = 1'b0;
    @(negedge ck);
    bus.load = 1'b0;
    repeat (8) @(negedge ck);            // e9
    chk("mid_an2", {3'b0, bus.an}, {3'b0, 4'b1011});
    set_digits(16'h5555, 4'b1111);
    bus.load = 1'b1;
    reset    = 1'b1;
    @(negedge ck);
    chk_reset_outputs("mid_rst");
    bus.load = 1'b0;
    reset    = 1'b0;
    @(negedge ck);
    chk("mid_first_an", {3'b0, bus.an}, {3'b0, 4'b1110});
    chk("mid_first_seg", bus.seg, 7'b1000000);
    chk("mid_first_dp", {6'b0, bus.dp}, 7'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
